// File: rtl/fir_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : fir_seq_mac
// Brief    : Time-multiplexed FIR (one MAC iterated over N_TAPS) with
//            double-buffered coefficients, rounding and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module fir_seq_mac #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int N_TAPS = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 11,
  parameter int SIGNED = 0
) (
  input  logic                      clk_78MHz,
  input  logic                      rst,
  input  logic                      en_fir_i,
  input  logic                      ready_i,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      coef_we_i,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr_i,
  input  logic [COEF_W-1:0]         coef_data_i,
  input  logic                      coef_commit_i,
  output logic [OUT_W-1:0]          data_fir_o,
  output logic                      valid_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int c_IDX_W  = $clog2(N_TAPS);
  localparam int c_CNT_W  = $clog2(N_TAPS + 1);
  localparam int c_PROD_W = DATA_W + COEF_W;
  localparam int c_ACC_W  = c_PROD_W + c_IDX_W;
  localparam int c_EXT_W  = ((c_ACC_W > OUT_W) ? c_ACC_W : OUT_W) + 2;

  localparam logic [c_IDX_W-1:0]        c_LAST = c_IDX_W'(N_TAPS - 1);
  localparam logic [c_CNT_W-1:0]        c_FULL = c_CNT_W'(N_TAPS);
  localparam logic signed [c_EXT_W-1:0] c_ONE  = c_EXT_W'(1);
  localparam logic signed [c_EXT_W-1:0] c_RND  = c_ONE <<< (SHIFT - 1);
  localparam logic signed [c_EXT_W-1:0] c_MAX  = (SIGNED != 0) ?
                                                 (c_ONE <<< (OUT_W - 1)) - c_ONE :
                                                 (c_ONE <<< OUT_W) - c_ONE;
  localparam logic signed [c_EXT_W-1:0] c_MIN  = (SIGNED != 0) ?
                                                 -(c_ONE <<< (OUT_W - 1)) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0]  r_x       [N_TAPS];
  logic [COEF_W-1:0]  r_shadow  [N_TAPS];
  logic [COEF_W-1:0]  r_active  [N_TAPS];
  logic [COEF_W-1:0]  w_shadow_next [N_TAPS];
  logic [c_ACC_W-1:0] r_acc;
  logic [c_IDX_W-1:0] r_k;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pending;

  logic w_accept;
  logic w_drop;
  logic w_copy;

  logic [DATA_W-1:0]         w_xk;
  logic [COEF_W-1:0]         w_ck;
  logic [c_PROD_W-1:0]       w_prod;
  logic [c_ACC_W-1:0]        w_prod_ext;
  logic [c_EXT_W-1:0]        w_acc_ext;
  logic signed [c_EXT_W-1:0] w_sum;
  logic signed [c_EXT_W-1:0] w_shr;
  logic [OUT_W-1:0]          w_sat;

  assign w_xk = r_x[r_k];
  assign w_ck = r_active[r_k];

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_prod     = $signed(w_xk) * $signed(w_ck);
      assign w_prod_ext = {{c_IDX_W{w_prod[c_PROD_W-1]}}, w_prod};
      assign w_acc_ext  = {{(c_EXT_W - c_ACC_W){r_acc[c_ACC_W-1]}}, r_acc};
    end else begin : g_unsigned
      assign w_prod     = w_xk * w_ck;
      assign w_prod_ext = {{c_IDX_W{1'b0}}, w_prod};
      assign w_acc_ext  = {{(c_EXT_W - c_ACC_W){1'b0}}, r_acc};
    end
  endgenerate

  // Headroom in c_EXT_W keeps the rounding add and the clamp compare exact.
  assign w_sum = $signed(w_acc_ext) + c_RND;
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_shr > c_MAX) begin
      w_sat = c_MAX[OUT_W-1:0];
    end else if (w_shr < c_MIN) begin
      w_sat = c_MIN[OUT_W-1:0];
    end
  end

  // A same-cycle write is folded into the value a commit copies.
  always_comb begin
    for (int i = 0; i < N_TAPS; i++) begin
      w_shadow_next[i] = r_shadow[i];
      if (coef_we_i && (coef_addr_i == c_IDX_W'(i))) begin
        w_shadow_next[i] = coef_data_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ready_i) begin
          w_accept     = 1'b1;
          w_state_next = S_MAC;
        end
      end
      S_MAC: begin
        w_drop = ready_i;
        if (r_k == c_LAST) begin
          w_state_next = S_OUT;
        end
      end
      S_OUT: begin
        w_drop       = ready_i;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Bank copy only at IDLE or on the OUT->IDLE edge, never mid-MAC.
    w_copy = ((r_state == S_IDLE) || (r_state == S_OUT)) &&
             (coef_commit_i || r_pending);
    if (!en_fir_i) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
      w_drop       = 1'b0;
      w_copy       = 1'b0;
    end
  end

  always_ff @(posedge clk_78MHz) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_shadow <= w_shadow_next;
    end
  end

  always_ff @(posedge clk_78MHz) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      data_fir_o <= '0;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        r_x[i]      <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (!en_fir_i) begin
        r_acc      <= '0;
        r_k        <= '0;
        r_cnt      <= '0;
        data_fir_o <= '0;
        valid_o    <= 1'b0;
        overrun_o  <= 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
          r_x[i] <= '0;
        end
      end else begin
        valid_o <= 1'b0;
        if (w_drop) begin
          overrun_o <= 1'b1;
        end
        if (w_accept) begin
          r_x[0] <= data_in;
          for (int i = 1; i < N_TAPS; i++) begin
            r_x[i] <= r_x[i-1];
          end
          r_acc <= '0;
          r_k   <= '0;
          if (r_cnt != c_FULL) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        if (r_state == S_MAC) begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + c_IDX_W'(1);
        end
        // Warm-up samples run full timing but leave the output untouched.
        if ((r_state == S_OUT) && (r_cnt == c_FULL)) begin
          data_fir_o <= w_sat;
          valid_o    <= 1'b1;
        end
        if (w_copy) begin
          r_active  <= w_shadow_next;
          r_pending <= 1'b0;
        end else if (coef_commit_i) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign busy_o = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_seq_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_seq_mac
// Brief    : Directed bench for fir_seq_mac; an unsigned and a signed
//            (SHIFT=10) instance share clock and control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_seq_mac;

  logic        clk_78MHz = 1'b0;
  logic        rst = 1'b1;
  logic        en_fir_i = 1'b1;
  logic        ready_i = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] s_data_in = '0;
  logic        coef_we_i = 1'b0;
  logic [3:0]  coef_addr_i = '0;
  logic [11:0] coef_data_i = '0;
  logic [11:0] s_coef_data_i = '0;
  logic        coef_commit_i = 1'b0;
  logic [15:0] data_fir_o, s_data_fir_o;
  logic        valid_o, s_valid_o, busy_o, s_busy_o, overrun_o, s_overrun_o;

  int n_total = 0;
  int n_bad   = 0;
  int lat_u, nval_u, lat_s, nval_s, nbusy;
  logic [15:0] dat_u, dat_s;

  always #5 clk_78MHz = ~clk_78MHz;

  fir_seq_mac u_dut (
    .clk_78MHz(clk_78MHz), .rst(rst), .en_fir_i(en_fir_i), .ready_i(ready_i),
    .data_in(data_in), .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i),
    .coef_data_i(coef_data_i), .coef_commit_i(coef_commit_i),
    .data_fir_o(data_fir_o), .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  fir_seq_mac #(.SHIFT(10), .SIGNED(1)) u_dut_s (
    .clk_78MHz(clk_78MHz), .rst(rst), .en_fir_i(en_fir_i), .ready_i(ready_i),
    .data_in(s_data_in), .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i),
    .coef_data_i(s_coef_data_i), .coef_commit_i(coef_commit_i),
    .data_fir_o(s_data_fir_o), .valid_o(s_valid_o), .busy_o(s_busy_o),
    .overrun_o(s_overrun_o)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 20-cycle sample slot with optional double strobe, mid-slot commit,
  // and mid-slot rst / en_fir_i-low abort (cycle numbers relative to accept).
  task automatic feed(input logic [11:0] d, input logic [11:0] sd, input bit dbl,
                      input int cm, input int ab_rst, input int ab_en);
    lat_u = 0; nval_u = 0; dat_u = '0; lat_s = 0; nval_s = 0; dat_s = '0; nbusy = 0;
    ready_i = 1'b1; data_in = d; s_data_in = sd;
    @(posedge clk_78MHz); #1;
    if (dbl) data_in = 12'd900;
    else ready_i = 1'b0;
    for (int c = 1; c < 20; c++) begin
      coef_commit_i = (c == cm);
      rst           = (c == ab_rst);
      en_fir_i      = (c != ab_en);
      @(posedge clk_78MHz); #1;
      ready_i = 1'b0; coef_commit_i = 1'b0; rst = 1'b0; en_fir_i = 1'b1;
      if (busy_o) nbusy++;
      if (valid_o) begin
        nval_u++;
        if (lat_u == 0) begin lat_u = c; dat_u = data_fir_o; end
      end
      if (s_valid_o) begin
        nval_s++;
        if (lat_s == 0) begin lat_s = c; dat_s = s_data_fir_o; end
      end
    end
  endtask

  task automatic put(input logic [11:0] d, input logic [11:0] sd);
    feed(d, sd, 1'b0, 0, 0, 0);
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_novalid"}, nval_u, 0);
  endtask

  task automatic expect_out(input string tag, input longint want);
    check({tag, "_lat"}, lat_u, 17);
    check({tag, "_pulses"}, nval_u, 1);
    check({tag, "_busy"}, nbusy, 16);
    check(tag, dat_u, want);
  endtask

  task automatic wr_coef(input int a, input logic [11:0] v, input logic [11:0] sv,
                         input bit cmt);
    coef_we_i = 1'b1; coef_addr_i = 4'(a); coef_data_i = v; s_coef_data_i = sv;
    coef_commit_i = cmt;
    @(posedge clk_78MHz); #1;
    coef_we_i = 1'b0; coef_commit_i = 1'b0;
  endtask

  task automatic pulse_en_low();
    en_fir_i = 1'b0;
    @(posedge clk_78MHz); #1;
    en_fir_i = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk_78MHz);
    #1; rst = 1'b0;
    check("rst_data", data_fir_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    check("rst_s_busy", s_busy_o, 0);
    check("rst_s_overrun", s_overrun_o, 0);

    // 1: unity-ish gain, warm-up and latency
    for (int k = 0; k < 16; k++) wr_coef(k, 12'd2048, 12'd2048, k == 15);
    for (int i = 1; i <= 15; i++) begin put(12'd100, 12'd0); expect_none("t1_warm"); end
    put(12'd100, 12'd0);
    expect_out("t1_out", 1600);

    // 2: impulse response after soft clear restarts warm-up
    pulse_en_low();
    for (int k = 0; k < 16; k++) wr_coef(k, 12'((k + 1) * 128), 12'd0, k == 15);
    for (int i = 1; i <= 15; i++) begin put(12'd0, 12'd0); expect_none("t2_warm"); end
    put(12'd2048, 12'd0);
    expect_out("t2_imp0", 128);
    for (int i = 1; i <= 16; i++) begin
      put(12'd0, 12'd0);
      expect_out("t2_imp", (i <= 15) ? (i + 1) * 128 : 0);
    end

    // 3: saturation, unsigned high and signed both rails
    for (int k = 0; k < 16; k++) wr_coef(k, 12'd4095, 12'h800, k == 15);
    for (int i = 1; i <= 16; i++) put(12'd4095, 12'h7FF);
    expect_out("t3_usat", 65535);
    check("t3_s_lat", lat_s, 17);
    check("t3_s_negsat", $signed(dat_s), -32768);
    for (int i = 1; i <= 16; i++) put(12'd0, 12'h800);
    check("t3_s_possat", $signed(dat_s), 32767);
    for (int i = 1; i <= 16; i++) put(12'd0, 12'd100);
    check("t3_s_neg", $signed(dat_s), -3200);

    // 4: overrun; output = x[0] + x[1]
    pulse_en_low();
    check("t4_ovr_clr", overrun_o, 0);
    for (int k = 0; k < 16; k++) wr_coef(k, (k < 2) ? 12'd2048 : 12'd0, 12'd0, k == 15);
    for (int i = 1; i <= 14; i++) begin put(12'd0, 12'd0); expect_none("t4_warm"); end
    feed(12'd700, 12'd0, 1'b1, 0, 0, 0);
    expect_none("t4_drop_nocount");
    check("t4_ovr_set", overrun_o, 1);
    put(12'd500, 12'd0);
    expect_out("t4_out1", 1200);
    put(12'd300, 12'd0);
    expect_out("t4_out2", 800);
    check("t4_ovr_sticky", overrun_o, 1);
    pulse_en_low();
    check("t4_ovr_en_clr", overrun_o, 0);

    // 5: commit during MAC applies only to the following sample
    for (int k = 0; k < 16; k++) wr_coef(k, 12'd1024, 12'd0, 1'b0);
    for (int i = 1; i <= 15; i++) begin put(12'd100, 12'd0); expect_none("t5_warm"); end
    feed(12'd100, 12'd0, 1'b0, 5, 0, 0);
    expect_out("t5_oldbank", 200);
    check("t5_idle", busy_o, 0);
    put(12'd100, 12'd0);
    expect_out("t5_newbank", 800);

    // 6a: rst mid-MAC wipes banks
    feed(12'd100, 12'd0, 1'b0, 0, 5, 0);
    expect_none("t6_rst_abort");
    check("t6_rst_busy", nbusy, 4);
    check("t6_rst_data", data_fir_o, 0);
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_busy_now", busy_o, 0);
    check("t6_rst_ovr", overrun_o, 0);
    for (int i = 1; i <= 15; i++) begin put(12'd100, 12'd0); expect_none("t6_rst_warm"); end
    put(12'd100, 12'd0);
    expect_out("t6_zero_bank", 0);

    // 6b: en_fir_i low mid-MAC keeps banks, restarts warm-up
    for (int k = 0; k < 16; k++) wr_coef(k, 12'd1024, 12'd0, k == 15);
    put(12'd100, 12'd0);
    expect_out("t6_reload", 800);
    feed(12'd100, 12'd0, 1'b0, 0, 0, 5);
    expect_none("t6_en_abort");
    check("t6_en_busy", nbusy, 4);
    check("t6_en_data", data_fir_o, 0);
    for (int i = 1; i <= 15; i++) begin put(12'd100, 12'd0); expect_none("t6_en_warm"); end
    put(12'd100, 12'd0);
    expect_out("t6_kept_bank", 800);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
